conv_window_feeder: RTL and testbench
=====================================

// Module: conv_window_feeder
// PURPOSE
// Upstream stage of the 3x3 FP16 convolution engine. Accepts a raster-order FP16 pixel stream
// preceded by 9 kernel weights. Emits one 3-row column group per cycle on the engine's
// data_in0/1/2, kernel_load and valid_in inputs. Generates the engine's valid_out strobe so
// data_out updates only for complete, in-row windows. Valid (unpadded) convolution.
// PARAMETERS
// DATA_WIDTH   16  pixel/weight width (FP16 bit pattern; never interpreted arithmetically here)
// IMG_WIDTH    28  pixels per image row (>= 3)
// IMG_HEIGHT   28  rows per image (>= 3)
// KERNEL_SIZE  3   fixed at 3; any other value is a elaboration-time $error
// PORTS
// clk             in   1             clock, all logic on posedge
// rst             in   1             synchronous active-high reset
// start           in   1             1-cycle pulse in IDLE begins a kernel+frame sequence
// pixel_in        in   DATA_WIDTH    weight (LOAD_KERNEL) or pixel (STREAM) data
// pixel_valid     in   1             pixel_in valid; transfer when pixel_valid && pixel_ready
// pixel_ready     out  1             high in LOAD_KERNEL and STREAM only
// conv_data0      out  DATA_WIDTH    to engine data_in0: top row (r-2) / kernel row 0
// conv_data1      out  DATA_WIDTH    to engine data_in1: middle row (r-1) / kernel row 1
// conv_data2      out  DATA_WIDTH    to engine data_in2: bottom row (r) / kernel row 2
// conv_valid_in   out  1             to engine valid_in
// conv_kernel_load out 1             to engine kernel_load
// conv_valid_out  out  1             to engine valid_out: engine data_out updates next edge
// out_row         out  clog2(H)      row index of window top for current conv_valid_out
// out_col         out  clog2(W)      column index of window left for current conv_valid_out
// busy            out  1             state != IDLE
// frame_done      out  1             1-cycle pulse when the last result strobe has issued
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters and delay pipe cleared.
//   Line-buffer RAM is not cleared; stale rows are never emitted.
// - FSM: IDLE -start-> LOAD_KERNEL -9 weights-> STREAM -H*W pixels-> DRAIN -pipe empty-> IDLE.
//   Entering IDLE pulses frame_done. start outside IDLE is ignored.
// - LOAD_KERNEL: weights arrive column-major w[0][c],w[1][c],w[2][c], c=0..2.
//   Every third accepted weight: next cycle drive {data2,data1,data0}={w2,w1,w0},
//   conv_valid_in=1, conv_kernel_load=1 (3 groups total).
// - STREAM: pixel (r,c) accepted; line buffers lb0 (row r-1) and lb1 (row r-2) each IMG_WIDTH deep.
//   Same cycle: read lb1[c], lb0[c]; write lb1[c]<=lb0[c], lb0[c]<=pixel.
//   If r>=2, next cycle: data0=lb1[c], data1=lb0[c], data2=pixel, conv_valid_in=1, kernel_load=0.
//   Rows 0,1 fill buffers only; conv_valid_in stays 0.
// - Latency: accepted pixel -> conv_valid_in is 1 cycle (registered outputs).
// - Result strobe: conv_valid_out = conv_valid_in delayed exactly 2 cycles, qualified by
//   emitted column c>=2 and kernel_load=0. This matches engine capture (1) plus result_reg (1).
//   Columns 0,1 of each row are suppressed because the engine window straddles rows there.
//   out_row=r-2, out_col=c-2 travel down the same 2-stage pipe.
// - Throughput: 1 pixel/cycle. Gaps in pixel_valid produce gaps in conv_valid_in; the engine
//   holds its window, so the delay pipe must carry bubbles, not stall.
// - DRAIN: wait until the last group's strobe has issued (2 cycles after last conv_valid_in), then IDLE.
// - Counters wrap: c IMG_WIDTH-1 -> 0 increments r; pixel at (H-1,W-1) moves STREAM->DRAIN.
// - rst mid-operation: immediate IDLE, pipe flushed, no frame_done, outputs 0 next cycle.
// TESTING
// T1 reset: assert rst 2 cycles mid-STREAM -> all outputs 0, busy=0, no frame_done.
// T2 kernel: weights 1..9 column-major -> 3 groups {3,2,1},{6,5,4},{9,8,7} with kernel_load=1.
// T3 W=H=4, pixels 0..15 back-to-back -> conv_valid_in for pixels 8..15.
//    conv_valid_out 4 times, (row,col)=(0,0),(0,1),(1,0),(1,1).
//    First group {data2,data1,data0}={8,4,0}.
// T4 same as T3 with pixel_valid toggling 1010 -> identical group/strobe sequence, only stretched.
// T5 start pulsed during STREAM -> ignored; frame completes; frame_done pulses exactly once.
// T6 two back-to-back frames (start the cycle after frame_done) -> frame 2 results never use
//    frame-1 rows.

Source files
------------

// File: rtl/conv_window_feeder.sv
// Front end of the 3x3 FP16 convolution engine: loads the kernel, then turns a raster pixel
// stream into 3-row column groups and a result strobe that only fires for complete windows.
module conv_window_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         pixel_in,
  input  logic                          pixel_valid,
  output logic                          pixel_ready,
  output logic [DATA_WIDTH-1:0]         conv_data0,
  output logic [DATA_WIDTH-1:0]         conv_data1,
  output logic [DATA_WIDTH-1:0]         conv_data2,
  output logic                          conv_valid_in,
  output logic                          conv_kernel_load,
  output logic                          conv_valid_out,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  if (KERNEL_SIZE != 3) begin : g_bad_kernel
    $error("conv_window_feeder supports KERNEL_SIZE == 3 only");
  end

  // pixel_in transfers on a rising edge where pixel_valid && pixel_ready; the source holds
  // pixel_in stable while pixel_valid is high and not yet accepted.
  typedef enum logic [1:0] {S_IDLE, S_LOAD_KERNEL, S_STREAM, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             ksub_q, ksub_d;
  logic [1:0]             kgrp_q, kgrp_d;
  logic [CW-1:0]          c_q, c_d;
  logic [RW-1:0]          r_q, r_d;
  logic [DATA_WIDTH-1:0]  w0_q, w0_d, w1_q, w1_d;
  logic [DATA_WIDTH-1:0]  data0_q, data0_d, data1_q, data1_d, data2_q, data2_d;
  logic                   valid_in_q, valid_in_d;
  logic                   kload_q, kload_d;
  logic [RW-1:0]          emit_row_q, emit_row_d;
  logic [CW-1:0]          emit_col_q, emit_col_d;
  logic                   p1_v_q, p1_v_d;
  logic [RW-1:0]          p1_row_q, p1_row_d;
  logic [CW-1:0]          p1_col_q, p1_col_d;
  logic                   vout_q, vout_d;
  logic [RW-1:0]          orow_q, orow_d;
  logic [CW-1:0]          ocol_q, ocol_d;
  logic                   fdone_q, fdone_d;

  logic [DATA_WIDTH-1:0]  lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]  lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]  lb0_rd, lb1_rd;
  logic                   accept;

  assign pixel_ready = (state_q == S_LOAD_KERNEL) || (state_q == S_STREAM);
  assign accept      = pixel_valid && pixel_ready;
  assign lb0_rd      = lb0[c_q];
  assign lb1_rd      = lb1[c_q];

  // Line buffers hold rows r-1 (lb0) and r-2 (lb1); never reset, rows 0/1 refill them per frame.
  always_ff @(posedge clk) begin
    if (state_q == S_STREAM && accept) begin
      lb1[c_q] <= lb0[c_q];
      lb0[c_q] <= pixel_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    ksub_d     = ksub_q;
    kgrp_d     = kgrp_q;
    c_d        = c_q;
    r_d        = r_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    valid_in_d = 1'b0;
    kload_d    = 1'b0;
    emit_row_d = emit_row_q;
    emit_col_d = emit_col_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_KERNEL;
          ksub_d  = 2'd0;
          kgrp_d  = 2'd0;
          c_d     = '0;
          r_d     = '0;
        end
      end
      S_LOAD_KERNEL: begin
        if (accept) begin
          case (ksub_q)
            2'd0: begin
              w0_d   = pixel_in;
              ksub_d = 2'd1;
            end
            2'd1: begin
              w1_d   = pixel_in;
              ksub_d = 2'd2;
            end
            default: begin
              data0_d    = w0_q;
              data1_d    = w1_q;
              data2_d    = pixel_in;
              valid_in_d = 1'b1;
              kload_d    = 1'b1;
              ksub_d     = 2'd0;
              kgrp_d     = kgrp_q + 2'd1;
              if (kgrp_q == 2'd2) state_d = S_STREAM;
            end
          endcase
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (r_q >= RW'(2)) begin
            data0_d    = lb1_rd;
            data1_d    = lb0_rd;
            data2_d    = pixel_in;
            valid_in_d = 1'b1;
            emit_row_d = r_q - RW'(2);
            emit_col_d = c_q;
          end
          if (c_q == COL_LAST) begin
            c_d = '0;
            r_d = r_q + RW'(1);
            if (r_q == ROW_LAST) state_d = S_DRAIN;
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!valid_in_q && !p1_v_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Two-stage strobe pipe tracks engine capture + result register; it carries bubbles.
    p1_v_d   = valid_in_q && !kload_q && (emit_col_q >= CW'(2));
    p1_row_d = emit_row_q;
    p1_col_d = emit_col_q - CW'(2);
    vout_d   = p1_v_q;
    orow_d   = p1_row_q;
    ocol_d   = p1_col_q;
    fdone_d  = (state_q == S_DRAIN) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ksub_q     <= '0;
      kgrp_q     <= '0;
      c_q        <= '0;
      r_q        <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      valid_in_q <= 1'b0;
      kload_q    <= 1'b0;
      emit_row_q <= '0;
      emit_col_q <= '0;
      p1_v_q     <= 1'b0;
      p1_row_q   <= '0;
      p1_col_q   <= '0;
      vout_q     <= 1'b0;
      orow_q     <= '0;
      ocol_q     <= '0;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ksub_q     <= ksub_d;
      kgrp_q     <= kgrp_d;
      c_q        <= c_d;
      r_q        <= r_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      valid_in_q <= valid_in_d;
      kload_q    <= kload_d;
      emit_row_q <= emit_row_d;
      emit_col_q <= emit_col_d;
      p1_v_q     <= p1_v_d;
      p1_row_q   <= p1_row_d;
      p1_col_q   <= p1_col_d;
      vout_q     <= vout_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      fdone_q    <= fdone_d;
    end
  end

  assign conv_data0       = data0_q;
  assign conv_data1       = data1_q;
  assign conv_data2       = data2_q;
  assign conv_valid_in    = valid_in_q;
  assign conv_kernel_load = kload_q;
  assign conv_valid_out   = vout_q;
  assign out_row          = orow_q;
  assign out_col          = ocol_q;
  assign busy             = (state_q != S_IDLE);
  assign frame_done       = fdone_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 4x4 image: kernel groups, pixel groups,
// result strobes and their timing, reset flush, stray start and back-to-back frames.
module tb_conv_window_feeder;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic [DW-1:0] conv_data0, conv_data1, conv_data2;
  logic          conv_valid_in, conv_kernel_load, conv_valid_out;
  logic [1:0]    out_row, out_col;
  logic          busy, frame_done;

  conv_window_feeder #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .conv_data0(conv_data0), .conv_data1(conv_data1), .conv_data2(conv_data2),
    .conv_valid_in(conv_valid_in), .conv_kernel_load(conv_kernel_load),
    .conv_valid_out(conv_valid_out), .out_row(out_row), .out_col(out_col),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt = 0;
  int gidx = 0;
  bit h1 = 1'b0;
  bit h2 = 1'b0;
  logic [48:0] grp_q[$];
  logic [48:0] exp_grp_q[$];
  logic [3:0]  strb_q[$];
  logic [3:0]  exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture groups/strobes and check each strobe lands exactly 2 cycles after its group.
  always @(negedge clk) begin
    bit flag;
    if (rst) begin
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      flag = 1'b0;
      if (conv_valid_in) begin
        grp_q.push_back({conv_kernel_load, conv_data2, conv_data1, conv_data0});
        if (!conv_kernel_load) begin
          flag = (gidx % W) >= 2;
          gidx++;
        end
      end
      if (conv_valid_out) strb_q.push_back({out_row, out_col});
      if (conv_valid_out || h2) check_eq("vout_timing", conv_valid_out, h2);
      if (frame_done) fd_cnt++;
      h2 = h1;
      h1 = flag;
    end
  end

  task automatic start_frame();
    gidx  = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] v);
    int guard = 0;
    pixel_in    = v;
    pixel_valid = 1'b1;
    @(negedge clk);
    while (!pixel_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("ready", pixel_ready, 1);
    @(posedge clk); #1;
    pixel_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    pixel_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    int guard = 0;
    while (!seen && guard < 200) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      guard++;
    end
    check_eq("frame_done_seen", seen, 1);
  endtask

  function automatic logic [DW-1:0] px(input logic [DW-1:0] base, input int r, input int c);
    return base + DW'(r * W + c);
  endfunction

  task automatic run_frame(input logic [DW-1:0] wbase, input logic [DW-1:0] pbase,
                           input bit gaps, input bit stray, input bit settle, input string name);
    int n;
    grp_q.delete(); strb_q.delete(); exp_grp_q.delete(); exp_q.delete();
    fd_cnt = 0;
    for (int g = 0; g < 3; g++)
      exp_grp_q.push_back({1'b1, wbase + DW'(3*g+2), wbase + DW'(3*g+1), wbase + DW'(3*g)});
    for (int r = 2; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        exp_grp_q.push_back({1'b0, px(pbase, r, c), px(pbase, r-1, c), px(pbase, r-2, c)});
        if (c >= 2) exp_q.push_back({2'(r-2), 2'(c-2)});
      end
    end
    start_frame();
    for (int k = 0; k < 9; k++) begin
      send_word(wbase + DW'(k));
      if (gaps) idle_cycle();
    end
    for (int i = 0; i < W*H; i++) begin
      if (stray && i == 5) start = 1'b1;
      send_word(pbase + DW'(i));
      start = 1'b0;
      if (gaps) idle_cycle();
    end
    wait_done();
    check_eq({name, "_grp_count"}, grp_q.size(), exp_grp_q.size());
    n = (grp_q.size() < exp_grp_q.size()) ? grp_q.size() : exp_grp_q.size();
    for (int i = 0; i < n; i++) check_eq({name, "_grp"}, grp_q[i], exp_grp_q[i]);
    check_eq({name, "_strb_count"}, strb_q.size(), exp_q.size());
    n = (strb_q.size() < exp_q.size()) ? strb_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({name, "_strb"}, strb_q[i], exp_q[i]);
    if (settle) begin
      repeat (4) @(negedge clk);
      check_eq({name, "_done_pulses"}, fd_cnt, 1);
      check_eq({name, "_busy_after"}, busy, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Power-on reset
    @(posedge clk); @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", pixel_ready, 0);
    check_eq("rst_vin", conv_valid_in, 0);
    check_eq("rst_vout", conv_valid_out, 0);
    check_eq("rst_kload", conv_kernel_load, 0);
    check_eq("rst_done", frame_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: reset mid-stream, right after the first strobe-qualified group is emitted
    start_frame();
    for (int k = 0; k < 9; k++) send_word(DW'(k + 1));
    for (int i = 0; i < 11; i++) send_word(DW'(i));
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_ready", pixel_ready, 0);
    check_eq("t1_vin", conv_valid_in, 0);
    check_eq("t1_vout", conv_valid_out, 0);
    check_eq("t1_kload", conv_kernel_load, 0);
    check_eq("t1_data", {conv_data2, conv_data1, conv_data0}, 0);
    check_eq("t1_rowcol", {out_row, out_col}, 0);
    check_eq("t1_done", frame_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    grp_q.delete(); strb_q.delete();
    fd_cnt = 0;
    repeat (5) @(negedge clk);
    check_eq("t1_no_done", fd_cnt, 0);
    check_eq("t1_no_strobe", strb_q.size(), 0);
    check_eq("t1_idle", busy, 0);
    @(posedge clk); #1;

    // T2+T3: weights 1..9, pixels 0..15 back-to-back
    run_frame(16'd1, 16'd0, 1'b0, 1'b0, 1'b1, "t3");
    // T4: same data with valid toggling 1010
    run_frame(16'd1, 16'd0, 1'b1, 1'b0, 1'b1, "t4");
    // T5: stray start during STREAM
    run_frame(16'd1, 16'd40, 1'b0, 1'b1, 1'b1, "t5");
    // T6: back-to-back frames with distinct data
    run_frame(16'd11, 16'd50, 1'b0, 1'b0, 1'b0, "t6a");
    run_frame(16'd21, 16'd100, 1'b0, 1'b0, 1'b1, "t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
